disp_scan_ctrl: RTL and testbench
=================================

# disp_scan_ctrl

Display controller for the 8-digit seven-segment display on the MIPS prototyping board. It accepts 32-bit values from the GPIO output path through a valid/ready handshake. In decimal mode it converts each value to BCD with an iterative shift-add-3 sequencer; in hex mode it passes the value through. The result is held in a display buffer and scanned one digit at a time. Its outputs drive per-digit nibbles into the existing bcd_to_7seg decoders plus active-low digit selects, replacing the free-running LED_MUX scan.

## Interface
- SCAN_DIV, 20000: clocks per digit slot; 20000 gives 5 kHz digit rate at 100 MHz.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low; reset=0 at a rising edge resets the block.
- value_in  in  32  value to display.
- load  in  1  request; the value is accepted when load=1 and ready=1 at a rising edge.
- mode_dec  in  1  sampled with the load; 1 means decimal (BCD), 0 means hex.
- blank_lz  in  1  leading-zero blanking enable; live, not latched.
- ready  out  1  1 when idle and able to accept a load.
- ovf  out  1  the last decimal load exceeded 99,999,999.
- digit_out  out  4  nibble for the currently selected digit.
- LEDSEL  out  8  active-low one-hot digit select; 8'hFF means the slot is blanked.

## Operation
- The FSM has three states: IDLE, CONV and DONE.
  - IDLE: ready=1. An accepted hex load captures value_in into the result register and goes to DONE. An accepted decimal load captures value_in into the 32-bit shift register, clears the 40-bit BCD accumulator (10 digits) and the iteration counter, and goes to CONV.
  - CONV: each cycle, add 3 to every BCD digit that is ≥5, then shift {bcd, bin} left by 1. The 6-bit counter increments each cycle; after the 32nd iteration the state goes to DONE.
  - DONE: writes the display buffer atomically and returns to IDLE.
    - Hex: buffer = captured value; ovf=0.
    - Decimal, top two BCD digits zero: buffer = low 8 BCD digits; ovf=0.
    - Decimal, top two BCD digits nonzero: buffer = 32'hEEEE_EEEE; ovf=1.
- A load while ready=0 is ignored. There is no queueing, and the in-flight conversion is not disturbed.
- During CONV the scan keeps showing the previous buffer. The buffer never holds a partial result.
- Scan logic:
  - A divider counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and the digit index advances 0→1→…→7→0.
  - The index is 3 bits; the divider is $clog2(SCAN_DIV) bits wide.
  - digit_out = buffer[4*idx+3 : 4*idx].
  - LEDSEL = ~(8'b1 << idx), unless the slot is blanked.
- Blanking: when blank_lz=1, any slot whose index is above the most significant nonzero nibble of the buffer drives LEDSEL=8'hFF. Digit 0 is never blanked, so a buffer of 0 still shows a single "0". blank_lz has no effect on the conversion.
- Reset values: state IDLE, ready=1, ovf=0, buffer=0, shift/BCD registers=0, divider=0, idx=0, digit_out=4'h0, LEDSEL=8'hFE.
- Reset during CONV or DONE aborts the conversion and applies the full reset values above. No partial buffer write occurs.

## Timing
- Let E0 be the rising edge at which the load is accepted.
  - Hex: ready=0 after E0; buffer and ovf update at E1; ready=1 after E1.
  - Decimal: ready=0 after E0. Iterations run at E1..E32, and the state is DONE after E32. Buffer and ovf update at E33; ready=1 after E33, so ready is low for exactly 33 cycles.
- A load held high continuously is re-accepted at the first edge after ready returns to 1.
- digit_out and LEDSEL are registered: they change on the same edge as idx and reflect the buffer value as of that edge. A buffer update mid-slot is visible on the next clock.
- Each digit slot lasts exactly SCAN_DIV cycles; a full frame is 8*SCAN_DIV cycles.
- Reset takes effect on the first rising edge with reset=0 and holds for as long as reset=0.

## Test plan
- Reset: assert reset=0 for 3 clocks, release → ready=1, ovf=0, LEDSEL=8'hFE, digit_out=0. With SCAN_DIV=4, LEDSEL steps FE, FD, FB, …, 7F, FE on 4-cycle boundaries (wrap check).
- Hex load: value_in=32'h1234_ABCD, mode_dec=0 → ready low for exactly 1 cycle; the scan shows D, C, B, A, 4, 3, 2, 1 for idx 0..7; ovf=0.
- Decimal load: value_in=12,345,678 → ready low for exactly 33 cycles; buffer=32'h1234_5678; ovf=0. Follow with value_in=99,999,999 → buffer=32'h9999_9999.
- Decimal overflow: value_in=100,000,000 → ovf=1 and buffer=32'hEEEE_EEEE. Then value_in=32'hFFFF_FFFF → ovf=1. Then hex 32'h0 → ovf=0.
- Busy/reset interaction:
  - Decimal load of 42, then load=1 with value_in=7 at cycles 5..20 → that load is ignored; buffer=32'h0000_0042.
  - A second decimal load aborted by reset=0 at cycle 10 → buffer=0, ready=1.
- Blanking: buffer=32'h0000_0042, blank_lz=1 → LEDSEL=8'hFF for idx 2..7, normal selects for idx 0..1. Buffer=0 → only idx 0 is active. With blank_lz=0, all 8 slots are active.

Source files
------------

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: accepts 32-bit values over a valid/ready handshake,
// optionally converts them to BCD (iterative shift-add-3), holds the result
// in a display buffer, and scans it onto an 8-digit seven-segment display.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-low
//   value_in   value to display
//   load       load request, accepted when load & ready
//   mode_dec   1 = decimal (BCD conversion), 0 = hex pass-through
//   blank_lz   leading-zero blanking enable (live)
//   ready      idle and able to accept a load
//   ovf        last decimal load exceeded 99,999,999
//   digit_out  nibble for the currently selected digit
//   LEDSEL     active-low one-hot digit select, 8'hFF = blanked slot
module disp_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 20000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value_in,
    input  logic        load,
    input  logic        mode_dec,
    input  logic        blank_lz,
    output logic        ready,
    output logic        ovf,
    output logic [3:0]  digit_out,
    output logic [7:0]  LEDSEL
);

    localparam int unsigned DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BIN_W   = 32;
    localparam int unsigned BCD_W   = 40;
    localparam int unsigned BCD_DIG = 10;
    localparam int unsigned CNT_W   = 6;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dec_q, dec_d;
    logic [31:0]        buf_q, buf_d;
    logic               ovf_q, ovf_d;
    logic               ready_q, ready_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [2:0]         idx_q, idx_d;
    logic [3:0]         digit_q, digit_d;
    logic [7:0]         sel_q, sel_d;
    logic [2:0]         top_nz;
    logic               accept;

    assign accept = load & ready_q;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = mode_dec ? S_CONV : S_DONE;
            S_CONV:  if (cnt_q == ITER_LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Add-3 correction for every BCD digit >= 5 ahead of the shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(BCD_DIG); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion datapath and buffer commit; hex loads reuse bin_q as the result register
    always_comb begin
        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        dec_d = dec_q;
        buf_d = buf_q;
        ovf_d = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    bin_d = value_in;
                    dec_d = mode_dec;
                    if (mode_dec) begin
                        bcd_d = '0;
                        cnt_d = '0;
                    end
                end
            end
            S_CONV: begin
                bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
            end
            S_DONE: begin
                if (!dec_q) begin
                    buf_d = bin_q;
                    ovf_d = 1'b0;
                end else if (bcd_q[BCD_W-1:32] != 8'h00) begin
                    buf_d = 32'hEEEE_EEEE;
                    ovf_d = 1'b1;
                end else begin
                    buf_d = bcd_q[31:0];
                    ovf_d = 1'b0;
                end
            end
            default: ;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    // Highest nonzero nibble of the buffer; 0 when the buffer is all zero
    always_comb begin
        top_nz = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (buf_q[4*i +: 4] != 4'h0) top_nz = 3'(i);
        end
    end

    // Scan divider, digit index and registered digit/select outputs
    always_comb begin
        div_d   = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        idx_d   = (div_q == DIV_LAST) ? idx_q + 3'd1 : idx_q;
        digit_d = buf_q[{idx_d, 2'b00} +: 4];
        sel_d   = (blank_lz && (idx_d > top_nz)) ? 8'hFF : ~(8'b1 << idx_d);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            buf_q   <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            div_q   <= '0;
            idx_q   <= '0;
            digit_q <= 4'h0;
            sel_q   <= 8'hFE;
        end else begin
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            buf_q   <= buf_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            digit_q <= digit_d;
            sel_q   <= sel_d;
        end
    end

    assign ready     = ready_q;
    assign ovf       = ovf_q;
    assign digit_out = digit_q;
    assign LEDSEL    = sel_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl: a cycle-level behavioural model
// (decimal digits by division, scan position from elapsed cycles) compared
// every cycle, plus directed literal checks.
module tb_disp_scan_ctrl;

    localparam int unsigned SD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] value_in;
    logic        load;
    logic        mode_dec;
    logic        blank_lz;
    logic        ready;
    logic        ovf;
    logic [3:0]  digit_out;
    logic [7:0]  LEDSEL;

    always #5 clk = ~clk;

    disp_scan_ctrl #(.SCAN_DIV(SD)) dut (
        .clk       (clk),
        .reset     (reset),
        .value_in  (value_in),
        .load      (load),
        .mode_dec  (mode_dec),
        .blank_lz  (blank_lz),
        .ready     (ready),
        .ovf       (ovf),
        .digit_out (digit_out),
        .LEDSEL    (LEDSEL)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_buf, m_pend;
    logic        m_ovf, m_pend_ovf;
    int          m_rem;
    int          m_tick;
    int          m_idx;
    logic [3:0]  m_digit;
    logic [7:0]  m_sel;
    logic        chk_en = 1'b0;

    function automatic logic [31:0] to_bcd(input logic [31:0] v);
        logic [31:0] r;
        longint unsigned x;
        r = '0;
        x = 64'(v);
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_sel(input logic [31:0] b, input int idx, input logic bl);
        int top;
        top = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[4*i +: 4] != 4'h0) top = i;
        end
        if (bl && idx > top) return 8'hFF;
        return 8'(~(8'b1 << idx));
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_buf   = '0;
            m_ovf   = 1'b0;
            m_rem   = 0;
            m_tick  = 0;
            m_digit = 4'h0;
            m_sel   = 8'hFE;
            chk_en  = 1'b1;
        end else begin
            m_tick  = m_tick + 1;
            m_idx   = (m_tick / int'(SD)) % 8;
            m_digit = m_buf[4*m_idx +: 4];
            m_sel   = exp_sel(m_buf, m_idx, blank_lz);
            if (m_rem > 0) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_buf = m_pend;
                    m_ovf = m_pend_ovf;
                end
            end else if (load) begin
                if (!mode_dec) begin
                    m_pend     = value_in;
                    m_pend_ovf = 1'b0;
                    m_rem      = 1;
                end else begin
                    m_rem = 33;
                    if (value_in > 32'd99999999) begin
                        m_pend     = 32'hEEEE_EEEE;
                        m_pend_ovf = 1'b1;
                    end else begin
                        m_pend     = to_bcd(value_in);
                        m_pend_ovf = 1'b0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready",     32'(ready),     32'(m_rem == 0));
            check("ovf",       32'(ovf),       32'(m_ovf));
            check("digit_out", 32'(digit_out), 32'(m_digit));
            check("LEDSEL",    32'(LEDSEL),    32'(m_sel));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic do_load(input logic [31:0] v, input logic dec, input int exp_low);
        int cnt;
        load     = 1'b1;
        value_in = v;
        mode_dec = dec;
        @(negedge clk);
        load = 1'b0;
        cnt  = 0;
        while (ready !== 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("ready_low_cycles", 32'(cnt), 32'(exp_low));
    endtask

    task automatic read_buf(output logic [31:0] v);
        v = '0;
        repeat (8 * SD + 2) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                if (LEDSEL == 8'(~(8'b1 << i))) v[4*i +: 4] = digit_out;
            end
        end
    endtask

    task automatic active_mask(output logic [7:0] m);
        m = '0;
        repeat (8 * SD + 2) begin
            @(negedge clk);
            if (LEDSEL != 8'hFF) m = m | ~LEDSEL;
        end
    endtask

    initial begin
        logic [31:0] v;
        logic [7:0]  msk;
        int          low;
        reset    = 1'b0;
        load     = 1'b0;
        value_in = '0;
        mode_dec = 1'b0;
        blank_lz = 1'b0;

        // Reset held for 3 clocks
        repeat (3) @(negedge clk);
        check("rst_ready",  32'(ready),     32'd1);
        check("rst_ovf",    32'(ovf),       32'd0);
        check("rst_LEDSEL", 32'(LEDSEL),    32'hFE);
        check("rst_digit",  32'(digit_out), 32'd0);
        reset = 1'b1;

        // Scan stepping and wrap
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (k == 4)  check("scan_idx1", 32'(LEDSEL), 32'hFD);
            if (k == 28) check("scan_idx7", 32'(LEDSEL), 32'h7F);
            if (k == 32) check("scan_wrap", 32'(LEDSEL), 32'hFE);
        end

        // Hex load
        do_load(32'h1234_ABCD, 1'b0, 1);
        read_buf(v);
        check("hex_buf", v, 32'h1234_ABCD);
        check("hex_ovf", 32'(ovf), 32'd0);

        // Decimal loads
        do_load(32'd12345678, 1'b1, 33);
        read_buf(v);
        check("dec_buf", v, 32'h1234_5678);
        check("dec_ovf", 32'(ovf), 32'd0);
        do_load(32'd99999999, 1'b1, 33);
        read_buf(v);
        check("dec_max_buf", v, 32'h9999_9999);

        // Decimal overflow, then clear with hex 0
        do_load(32'd100000000, 1'b1, 33);
        read_buf(v);
        check("ovf_buf", v, 32'hEEEE_EEEE);
        check("ovf_flag", 32'(ovf), 32'd1);
        do_load(32'hFFFF_FFFF, 1'b1, 33);
        check("ovf_flag_ffff", 32'(ovf), 32'd1);
        do_load(32'h0, 1'b0, 1);
        check("ovf_cleared", 32'(ovf), 32'd0);

        // Blanking with a zero buffer
        blank_lz = 1'b1;
        active_mask(msk);
        check("blank_zero_mask", 32'(msk), 32'h01);
        blank_lz = 1'b0;

        // Busy: load of 7 during conversion of 42 is ignored
        load     = 1'b1;
        value_in = 32'd42;
        mode_dec = 1'b1;
        low      = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (ready !== 1'b1) low++;
            load     = (c >= 5 && c <= 20);
            value_in = 32'd7;
        end
        load = 1'b0;
        check("busy_ready_low", 32'(low), 32'd33);
        read_buf(v);
        check("busy_buf", v, 32'h0000_0042);

        // Blanking with 42
        blank_lz = 1'b1;
        active_mask(msk);
        check("blank_42_mask", 32'(msk), 32'h03);
        blank_lz = 1'b0;
        active_mask(msk);
        check("noblank_mask", 32'(msk), 32'hFF);

        // Conversion aborted by reset
        load     = 1'b1;
        value_in = 32'd12345678;
        mode_dec = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_ready", 32'(ready), 32'd1);
        read_buf(v);
        check("abort_buf", v, 32'h0);
        check("abort_ovf", 32'(ovf), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
